// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side end of the datapath load/store interface. One request at a
//   time is accepted over valid/ready, held for a fixed latency, and then
//   answered with a single-cycle response pulse. Accesses are sized and
//   signed according to the RISC-V funct3 encoding. Storage is little-endian
//   32-bit words. Misaligned, out-of-range and illegal-funct3 accesses return
//   an error and never modify memory.
//
// Parameters
//   ADDR_WIDTH  word-address bits; depth = 2**ADDR_WIDTH words (must be < 30)
//   LATENCY     edges from request accept to resp_valid (>= 1)
//
// Ports
//   rclk        clock, rising edge
//   rst         synchronous active-low reset
//   req_valid   request present
//   req_ready   responder idle and able to accept a request
//   req_write   1 = store, 0 = load
//   req_funct3  access size / sign (LB LH LW LBU LHU SB SH SW)
//   req_addr    byte address
//   req_wdata   store data, low bytes used for SB/SH
//   resp_valid  one-cycle response pulse
//   resp_rdata  load result; 0 for stores and errors
//   resp_err    access rejected, qualified by resp_valid

module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        rclk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_write;
  logic [2:0]        lat_funct3;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;

  logic [31:0]       mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           cur_word;
  logic                  out_of_range;
  logic                  access_now;

  logic                  acc_err;
  logic [31:0]           load_data;
  logic [31:0]           store_word;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_rep;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;

  assign word_idx     = lat_addr[ADDR_WIDTH+1:2];
  assign lane         = lat_addr[1:0];
  assign cur_word     = mem[word_idx];
  assign out_of_range = |lat_addr[31:ADDR_WIDTH+2];
  assign access_now   = (state == BUSY) && (cnt == '0);

  // Decode the latched request: error detection, load extraction and the
  // merged word a store would write back (read-modify-write of one word).
  always_comb begin
    acc_err    = 1'b0;
    load_data  = 32'd0;
    store_word = cur_word;
    byte_en    = 4'b0000;
    wdata_rep  = lat_wdata;
    byte_val   = cur_word[{lane, 3'b000} +: 8];
    half_val   = lane[1] ? cur_word[31:16] : cur_word[15:0];

    // Stores only have 000/001/010; loads additionally allow 100/101.
    if (lat_write)
      acc_err = (lat_funct3 > 3'd2);
    else
      acc_err = (lat_funct3 == 3'd3) || (lat_funct3 == 3'd6) || (lat_funct3 == 3'd7);

    if ((lat_funct3[1:0] == 2'b01) && lane[0])
      acc_err = 1'b1;
    if ((lat_funct3[1:0] == 2'b10) && (lane != 2'b00))
      acc_err = 1'b1;
    if (out_of_range)
      acc_err = 1'b1;

    case (lat_funct3)
      3'b000:  load_data = {{24{byte_val[7]}}, byte_val};
      3'b001:  load_data = {{16{half_val[15]}}, half_val};
      3'b010:  load_data = cur_word;
      3'b100:  load_data = {24'd0, byte_val};
      3'b101:  load_data = {16'd0, half_val};
      default: load_data = 32'd0;
    endcase
    if (acc_err || lat_write)
      load_data = 32'd0;

    // Replicate store data across lanes so the byte enables pick it out.
    case (lat_funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{lat_wdata[15:0]}};
      end
      2'b10: begin
        byte_en   = 4'b1111;
        wdata_rep = lat_wdata;
      end
      default: begin
        byte_en   = 4'b0000;
        wdata_rep = lat_wdata;
      end
    endcase

    for (int i = 0; i < 4; i++)
      if (byte_en[i])
        store_word[8*i +: 8] = wdata_rep[8*i +: 8];
  end

  // Request/response sequencing. All handshake outputs are registered.
  always_ff @(posedge rclk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            cnt        <= CNT_LOAD;
            req_ready  <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= acc_err;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Store commit happens on the edge that enters RESP; a reset on that edge
  // discards it. The array itself is never cleared.
  always_ff @(posedge rclk) begin
    if (rst && access_now && lat_write && !acc_err)
      mem[word_idx] <= store_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Scoreboard bench for data_mem_responder (ADDR_WIDTH=8, LATENCY=2).
//   Stimulus pushes expected responses from a byte-addressed reference model;
//   a monitor pops and compares whenever resp_valid is seen.

module tb_data_mem_responder;

  localparam int ADDR_WIDTH = 8;
  localparam int LATENCY    = 2;
  localparam int MEM_BYTES  = 4 << ADDR_WIDTH;

  logic        rclk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mbytes [0:MEM_BYTES-1];
  int          checks   = 0;
  int          failures = 0;
  int          cycle    = 0;
  bit          rst_at_edge = 1'b0;
  bit          prev_valid  = 1'b0;
  logic [31:0] prev_rdata;
  logic        prev_err;

  data_mem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
    .rclk       (rclk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  always @(posedge rclk) begin
    cycle       <= cycle + 1;
    rst_at_edge <= rst;
  end

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: byte-addressed little-endian memory with the access
  // rules applied directly (size, alignment, range, legal encodings).
  function automatic void model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output bit e);
    int          nbytes;
    bit          sgn;
    bit          legal;
    logic [31:0] value;
    nbytes = 1;
    sgn    = 1'b0;
    case (f3)
      3'd0: begin nbytes = 1; sgn = 1'b1; end
      3'd1: begin nbytes = 2; sgn = 1'b1; end
      3'd2: begin nbytes = 4; sgn = 1'b0; end
      3'd4: begin nbytes = 1; sgn = 1'b0; end
      3'd5: begin nbytes = 2; sgn = 1'b0; end
      default: begin nbytes = 1; sgn = 1'b0; end
    endcase
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e  = !legal || ((a % nbytes) != 0) || (a >= MEM_BYTES);
    rd = 32'd0;
    if (e) return;
    if (wr) begin
      for (int i = 0; i < nbytes; i++)
        mbytes[a + i] = wd[8*i +: 8];
    end else begin
      value = 32'd0;
      for (int i = 0; i < nbytes; i++)
        value = value | (32'(mbytes[a + i]) << (8 * i));
      if (sgn && nbytes < 4 && value[8*nbytes-1])
        value = value - (32'd1 << (8 * nbytes));
      rd = value;
    end
  endfunction

  task automatic waitReady();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge rclk);
      n++;
    end
    checkOutput("ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  // Issue one request; optionally keep req_valid high through busy/resp.
  task automatic applyStimulus(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input bit hold);
    exp_t e;
    bit   err;
    @(negedge rclk);
    waitReady();
    model(wr, f3, a, wd, e.rdata, err);
    e.err = err;
    e.cyc = cycle + 1 + LATENCY;
    sb.push_back(e);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge rclk);
    @(negedge rclk);
    if (hold)
      repeat (LATENCY + 1) @(negedge rclk);
    req_valid = 1'b0;
  endtask

  // Monitor: compare each response with the oldest expectation, and check
  // that response data holds after the pulse.
  always @(negedge rclk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("resp_rdata", resp_rdata, e.rdata);
        checkOutput("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        checkOutput("resp_cycle", cycle, e.cyc);
        checkOutput("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
      end
      prev_valid = 1'b1;
      prev_rdata = resp_rdata;
      prev_err   = resp_err;
    end else begin
      if (prev_valid && rst_at_edge) begin
        checkOutput("rdata_hold", resp_rdata, prev_rdata);
        checkOutput("err_hold", {31'd0, resp_err}, {31'd0, prev_err});
        checkOutput("ready_after_resp", {31'd0, req_ready}, 32'd1);
      end
      prev_valid = 1'b0;
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    checkOutput({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
    checkOutput({tag, "_rdata"}, resp_rdata, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, resp_err}, 32'd0);
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) mbytes[i] = 8'h00;

    repeat (2) @(posedge rclk);
    @(negedge rclk);
    checkResetState("reset");
    rst = 1'b1;

    // Store/load basics and sub-word extraction.
    applyStimulus(1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    applyStimulus(0, 3'd2, 32'h10, 32'h0, 0);
    applyStimulus(0, 3'd0, 32'h13, 32'h0, 0);
    applyStimulus(0, 3'd4, 32'h13, 32'h0, 0);
    applyStimulus(0, 3'd1, 32'h12, 32'h0, 0);
    applyStimulus(0, 3'd5, 32'h12, 32'h0, 0);
    applyStimulus(1, 3'd0, 32'h11, 32'h00000055, 0);
    applyStimulus(0, 3'd2, 32'h10, 32'h0, 0);
    applyStimulus(1, 3'd1, 32'h12, 32'h00001234, 0);
    applyStimulus(0, 3'd2, 32'h10, 32'h0, 0);

    // Error cases.
    applyStimulus(0, 3'd2, 32'h12, 32'h0, 0);
    applyStimulus(1, 3'd1, 32'h11, 32'hAAAA5555, 0);
    applyStimulus(0, 3'd2, 32'h10, 32'h0, 0);
    applyStimulus(0, 3'd2, 32'h400, 32'h0, 0);
    applyStimulus(0, 3'd3, 32'h10, 32'h0, 0);
    applyStimulus(1, 3'd4, 32'h10, 32'h0, 0);

    // Reset during BUSY aborts the in-flight store.
    applyStimulus(1, 3'd2, 32'h20, 32'h00000001, 0);
    @(negedge rclk);
    waitReady();
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h20;
    req_wdata  = 32'h00000002;
    @(posedge rclk);
    @(negedge rclk);
    req_valid = 1'b0;
    rst       = 1'b0;
    @(negedge rclk);
    rst = 1'b1;
    checkResetState("abort");
    repeat (6) @(negedge rclk);
    applyStimulus(0, 3'd2, 32'h20, 32'h0, 0);

    // req_valid held across busy: only one acceptance.
    applyStimulus(0, 3'd2, 32'h10, 32'h0, 1);

    // Give the random phase a fully known region.
    for (int w = 0; w < 16; w++)
      applyStimulus(1, 3'd2, 32'(w * 4), $urandom, 0);

    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0)
        a = 32'(MEM_BYTES) + $urandom_range(0, 4000);
      else
        a = $urandom_range(0, 63);
      applyStimulus($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, $urandom,
                    $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge rclk);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge rclk);
      n++;
    end
    checkOutput("sb_drain", sb.size(), 32'd0);
    repeat (10) @(negedge rclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
